// File: rtl/mmm_pkg.sv
// mmm_pkg: shared front-end types and widths for the BTB and prediction tracking.
package mmm_pkg;
    localparam int XLEN   = 32;
    localparam int OFFSET = 2;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [XLEN-OFFSET-1:0] target;
    } resolution_t;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic                   hit;
        logic [XLEN-OFFSET-1:0] target;
    } pred_entry_t;
endpackage

// File: rtl/branch_resolver_pred_fifo.sv
// pred_fifo: in-order queue of predictions with synchronous clear and occupancy count.
module pred_fifo
    import mmm_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  pred_entry_t                wdata_i,
    output pred_entry_t                rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pred_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign do_push = push_i && (count_o != CW'(DEPTH));
    assign do_pop  = pop_i && (count_o != '0);
    assign rdata_o = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i && !rst_i)
            mem[wr_ptr] <= wdata_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count_o <= count_o + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: tracks in-flight predictions and resolves them against execute outcomes,
// producing registered BTB updates and front-end redirects.
module branch_resolver
    import mmm_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      pred_valid_i,
    output logic                      pred_ready_o,
    input  logic [XLEN-1:0]           pred_pc_i,
    input  logic                      pred_hit_i,
    input  logic [XLEN-OFFSET-1:0]    pred_target_i,
    input  logic                      exec_valid_i,
    output logic                      exec_ready_o,
    input  logic                      exec_taken_i,
    input  logic [XLEN-1:0]           exec_target_i,
    output logic                      res_valid_o,
    output logic                      del_entry_o,
    output resolution_t               res_o,
    output logic                      mispredict_o,
    output logic [XLEN-1:0]           redirect_pc_o,
    output logic [$clog2(DEPTH):0]    count_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    pred_entry_t            head;
    logic                   push, pop, resolve, mispred;
    logic [XLEN-OFFSET-1:0] ttgt;

    assign pred_ready_o = count_o != CW'(DEPTH);
    assign exec_ready_o = count_o != '0;
    assign push         = pred_valid_i && pred_ready_o;
    assign pop          = exec_valid_i && exec_ready_o;
    assign resolve      = pop && !flush_i;
    assign ttgt         = exec_target_i[XLEN-1:OFFSET];
    assign mispred      = (head.hit != exec_taken_i) || (head.hit && exec_taken_i && head.target != ttgt);

    // A mispredict squashes every younger entry, including a same-cycle push.
    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (flush_i || (pop && mispred)),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ('{pc: pred_pc_i, hit: pred_hit_i, target: pred_target_i}),
        .rdata_o (head),
        .count_o (count_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_valid_o   <= 1'b0;
            del_entry_o   <= 1'b0;
            mispredict_o  <= 1'b0;
            res_o         <= '0;
            redirect_pc_o <= '0;
        end else begin
            res_valid_o  <= resolve && (exec_taken_i || head.hit);
            del_entry_o  <= resolve && !exec_taken_i && head.hit;
            mispredict_o <= resolve && mispred;
            if (resolve) begin
                res_o         <= '{pc: head.pc, target: ttgt};
                redirect_pc_o <= exec_taken_i ? exec_target_i : head.pc + XLEN'(1 << OFFSET);
            end
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed and randomized checks against a queue-based reference model.
module tb_branch_resolver;
    import mmm_pkg::*;
    localparam int DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0, flush_i = 1'b0, pred_valid_i = 1'b0, pred_hit_i = 1'b0;
    logic        exec_valid_i = 1'b0, exec_taken_i = 1'b0;
    logic [31:0] pred_pc_i = '0, exec_target_i = '0;
    logic [29:0] pred_target_i = '0;
    logic        pred_ready_o, exec_ready_o, res_valid_o, del_entry_o, mispredict_o;
    resolution_t res_o;
    logic [31:0] redirect_pc_o;
    logic [3:0]  count_o;

    branch_resolver #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .pred_valid_i(pred_valid_i), .pred_ready_o(pred_ready_o), .pred_pc_i(pred_pc_i),
        .pred_hit_i(pred_hit_i), .pred_target_i(pred_target_i),
        .exec_valid_i(exec_valid_i), .exec_ready_o(exec_ready_o), .exec_taken_i(exec_taken_i),
        .exec_target_i(exec_target_i), .res_valid_o(res_valid_o), .del_entry_o(del_entry_o),
        .res_o(res_o), .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0, n_fail = 0;
    pred_entry_t q[$];
    bit          e_rv, e_del, e_mis;
    logic [31:0] e_pc, e_redir;
    logic [29:0] e_tgt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle from a negedge, advance the model, then check at the next negedge.
    task automatic cycle(input bit r, input bit f, input bit pv, input logic [31:0] pc, input bit hit,
                         input logic [29:0] tgt, input bit ev, input bit taken, input logic [31:0] etgt);
        bit          can_push, do_pop, mis;
        pred_entry_t e;
        rst_i = r; flush_i = f; pred_valid_i = pv; pred_pc_i = pc; pred_hit_i = hit;
        pred_target_i = tgt; exec_valid_i = ev; exec_taken_i = taken; exec_target_i = etgt;
        e_rv = 0; e_del = 0; e_mis = 0;
        if (r) begin
            q.delete();
            e_pc = '0; e_tgt = '0; e_redir = '0;
        end else if (f) begin
            q.delete();
        end else begin
            can_push = pv && q.size() < DEPTH;
            do_pop   = ev && q.size() > 0;
            mis      = 0;
            if (do_pop) begin
                e       = q.pop_front();
                mis     = (e.hit != taken) || (e.hit && taken && e.target != etgt[31:2]);
                e_rv    = taken || e.hit;
                e_del   = !taken && e.hit;
                e_mis   = mis;
                e_pc    = e.pc;
                e_tgt   = etgt[31:2];
                e_redir = taken ? etgt : e.pc + 32'd4;
                if (mis) q.delete();
            end
            if (can_push && !mis) q.push_back('{pc: pc, hit: hit, target: tgt});
        end
        @(posedge clk_i);
        @(negedge clk_i);
        check_eq("count", count_o, q.size());
        check_eq("pred_ready", pred_ready_o, q.size() < DEPTH);
        check_eq("exec_ready", exec_ready_o, q.size() > 0);
        check_eq("res_valid", res_valid_o, e_rv);
        check_eq("del_entry", del_entry_o, e_del);
        check_eq("mispredict", mispredict_o, e_mis);
        if (e_rv) check_eq("res_pc", res_o.pc, e_pc);
        if (e_rv && !e_del) check_eq("res_target", res_o.target, e_tgt);
        if (e_mis) check_eq("redirect_pc", redirect_pc_o, e_redir);
        if (r) begin
            check_eq("rst_res", res_o, '0);
            check_eq("rst_redirect", redirect_pc_o, '0);
        end
    endtask

    task automatic push(input logic [31:0] pc, input bit hit, input logic [29:0] tgt);
        cycle(0, 0, 1, pc, hit, tgt, 0, 0, '0);
    endtask

    task automatic pop(input bit taken, input logic [31:0] etgt);
        cycle(0, 0, 0, '0, 0, '0, 1, taken, etgt);
    endtask

    initial begin
        bit          r, f, pv, hit, ev, taken;
        logic [31:0] pc, etgt;
        logic [29:0] tgt;
        @(negedge clk_i);
        cycle(1, 0, 0, '0, 0, '0, 0, 0, '0);
        push(32'h100, 1, 30'h80);
        pop(1, 32'h200);
        push(32'h104, 0, '0);
        for (int i = 0; i < 3; i++) push(32'h110 + 32'(4 * i), 0, '0);
        pop(1, 32'h300);
        push(32'h108, 1, 30'h80);
        pop(0, '0);
        push(32'h10C, 0, '0);
        pop(0, '0);
        for (int i = 0; i < 9; i++) push(32'h400 + 32'(4 * i), 0, '0);
        cycle(0, 0, 1, 32'h500, 0, '0, 1, 0, '0);
        cycle(0, 1, 0, '0, 0, '0, 0, 0, '0);
        for (int i = 0; i < 3; i++) push(32'h600 + 32'(4 * i), 1, 30'h40);
        cycle(0, 1, 1, 32'h700, 0, '0, 1, 1, 32'h100);
        push(32'h800, 1, 30'h10);
        push(32'h804, 0, '0);
        cycle(1, 0, 1, 32'h808, 0, '0, 1, 1, 32'h40);
        push(32'hFFFFFFFC, 1, 30'h123);
        pop(0, '0);
        for (int i = 0; i < 600; i++) begin
            r     = $urandom_range(199) == 0;
            f     = $urandom_range(59) == 0;
            pv    = $urandom_range(3) != 0;
            pc    = $urandom & 32'hFFFFFFFC;
            hit   = $urandom_range(1) == 1;
            tgt   = 30'($urandom_range(7));
            ev    = $urandom_range(2) != 0;
            taken = $urandom_range(1) == 1;
            etgt  = {30'($urandom_range(7)), 2'($urandom)};
            if (q.size() > 0 && $urandom_range(7) != 0) begin
                taken = q[0].hit;
                etgt  = {q[0].target, 2'($urandom)};
            end
            cycle(r, f, pv, pc, hit, tgt, ev, taken, etgt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
